// File: rtl/jtkicker_sprgen_if.sv
// rtl/jtkicker_sprgen_if.sv - object table, sprite ROM and line buffer bus of the sprite engine
// Ports (master = sprite engine, slave = memories):
//   obj_addr/obj_data        object table read, {index, byte}
//   rom_addr/rom_cs/rom_ok/rom_data  graphics ROM request and 8-pixel response
//   buf_addr/buf_data/buf_we line buffer write
interface jtkicker_sprgen_if #(
  parameter int OBJW = 5,
  parameter int CW   = 8,
  parameter int BPP  = 4,
  parameter int PALW = 4
);
  logic [OBJW+1:0]      obj_addr;
  logic [7:0]           obj_data;
  logic [CW+4:0]        rom_addr;
  logic                 rom_cs;
  logic                 rom_ok;
  logic [8*BPP-1:0]     rom_data;
  logic [7:0]           buf_addr;
  logic [PALW+BPP-1:0]  buf_data;
  logic                 buf_we;

  modport master (
    output obj_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    input  obj_data, rom_ok, rom_data
  );

  modport slave (
    input  obj_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    output obj_data, rom_ok, rom_data
  );
endinterface

// File: rtl/jtkicker_sprgen.sv
// rtl/jtkicker_sprgen.sv - per-scanline sprite scanner and line buffer drawer
// Ports:
//   rst      asynchronous reset, active-high
//   clk      system clock
//   cen      step enable, all state advances only on cen
//   hinit    start of line; also aborts and restarts a scan in progress
//   vrender  line being prepared
//   bus      object table / ROM / line buffer bus (master side)
//   busy     scan or draw in progress
//   ovf      per-line sprite limit reached, held until next hinit
module jtkicker_sprgen #(
  parameter int OBJW    = 5,
  parameter int CW      = 8,
  parameter int BPP     = 4,
  parameter int PALW    = 4,
  parameter int MAXLINE = 8,
  parameter int XMIN    = 24,
  parameter int HOFFSET = 6
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                cen,
  input  logic                hinit,
  input  logic [7:0]          vrender,
  jtkicker_sprgen_if.master   bus,
  output logic                busy,
  output logic                ovf
);

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_CODE, RD_ATTR, RD_X, CHECK, FETCH, WRITE, NEXT
  } state_t;

  localparam logic [OBJW:0] MAXL = (OBJW+1)'(MAXLINE);

  state_t            state, next_state;
  logic [OBJW-1:0]   idx;
  logic [1:0]        bsel;
  logic [7:0]        ypos, xpos;
  logic [CW-1:0]     code;
  logic [PALW-1:0]   pal;
  logic              vflip, hflip;
  logic              half, second;
  logic [2:0]        cnt;
  logic [8*BPP-1:0]  pixels;
  logic [OBJW:0]     drawn;
  logic [7:0]        waddr;
  logic [CW+4:0]     rom_addr_r;
  logic              ovf_r;
  logic              hinit_pend;

  // A one-clk hinit may fall between cen steps, so it is held until consumed.
  logic start;
  assign start = cen & (hinit | hinit_pend);

  logic [7:0]     dy;
  logic [3:0]     row;
  logic           draw;
  logic [2:0]     pix_sel;
  logic [BPP-1:0] pix;

  assign dy      = vrender - ypos;
  assign row     = dy[3:0] ^ {4{vflip}};
  assign draw    = (dy[7:4] == 4'd0) && (xpos > 8'(XMIN));
  // Step order is always 0..7; hflip only reverses which pixel is taken.
  assign pix_sel = hflip ? ~cnt : cnt;
  assign pix     = pixels[32'(pix_sel)*BPP +: BPP];

  assign bus.obj_addr = {idx, bsel};
  assign bus.rom_addr = rom_addr_r;
  assign bus.buf_addr = waddr;
  assign bus.buf_data = {pal, pix};
  assign ovf          = ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    busy        = (state != IDLE);
    bus.rom_cs  = (state == FETCH);
    // Suppressed on the abort step so nothing is written after hinit.
    bus.buf_we  = (state == WRITE) && cen && !start && (pix != '0);
    if (cen) begin
      if (start) next_state = RD_Y;
      else begin
        case (state)
          IDLE:    next_state = IDLE;
          RD_Y:    next_state = RD_CODE;
          RD_CODE: next_state = RD_ATTR;
          RD_ATTR: next_state = RD_X;
          RD_X:    next_state = CHECK;
          CHECK:   next_state = draw ? FETCH : NEXT;
          FETCH:   if (bus.rom_ok) next_state = WRITE;
          WRITE:   if (cnt == 3'd7) next_state = second ? NEXT : FETCH;
          NEXT:    next_state = (drawn == MAXL || idx == '1) ? IDLE : RD_Y;
          default: next_state = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0; bsel <= '0; ypos <= '0; xpos <= '0; code <= '0;
      pal <= '0; vflip <= 1'b0; hflip <= 1'b0; half <= 1'b0; second <= 1'b0;
      cnt <= '0; pixels <= '0; drawn <= '0; waddr <= '0; rom_addr_r <= '0;
      ovf_r <= 1'b0; hinit_pend <= 1'b0;
    end else begin
      hinit_pend <= cen ? 1'b0 : (hinit_pend | hinit);
      if (cen) begin
        if (start) begin
          idx   <= '0;
          bsel  <= '0;
          drawn <= '0;
          ovf_r <= 1'b0;
        end else begin
          case (state)
            RD_Y: begin
              ypos <= ~bus.obj_data;
              bsel <= bsel + 2'd1;
            end
            RD_CODE: begin
              code <= CW'(bus.obj_data);
              bsel <= bsel + 2'd1;
            end
            RD_ATTR: begin
              pal   <= bus.obj_data[PALW-1:0];
              hflip <= bus.obj_data[6];
              vflip <= bus.obj_data[7];
              bsel  <= bsel + 2'd1;
            end
            RD_X: begin
              xpos <= bus.obj_data;
              bsel <= bsel + 2'd1;
            end
            CHECK: if (draw) begin
              half       <= hflip;
              second     <= 1'b0;
              waddr      <= xpos + 8'(HOFFSET) + (hflip ? 8'd15 : 8'd0);
              rom_addr_r <= {code, row, hflip};
            end
            FETCH: if (bus.rom_ok) begin
              pixels <= bus.rom_data;
              cnt    <= '0;
            end
            WRITE: begin
              cnt   <= cnt + 3'd1;
              waddr <= hflip ? waddr - 8'd1 : waddr + 8'd1;
              if (cnt == 3'd7) begin
                if (!second) begin
                  second     <= 1'b1;
                  half       <= ~half;
                  rom_addr_r <= {code, row, ~half};
                end else begin
                  drawn <= drawn + 1'b1;
                end
              end
            end
            NEXT: begin
              if (drawn == MAXL) ovf_r <= 1'b1;
              else if (idx != '1) idx <= idx + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/jtkicker_sprgen.md
Name: jtkicker_sprgen

Overview:
Parametrised sprite line engine, the next generation of the Kicker object scanner/drawer. Once per scanline it scans an external object table, selects objects that intersect the next line, and fetches 16-pixel-wide graphics rows from SDRAM. It writes non-transparent pixels into an external line buffer. Additions over the previous generation: configurable object count, bit depth and code width; a per-line sprite limit with an overflow flag; transparent-pixel skipping; abort/restart on hinit.

Parameters:
OBJW, 5, log2 of object count; the table holds 2**OBJW entries of 4 bytes.
CW, 8, tile code width in bits.
BPP, 4, bits per pixel; rom_data carries 8 pixels, so rom_data width is 8*BPP.
PALW, 4, palette-select bits taken from attr[PALW-1:0].
MAXLINE, 8, maximum sprites drawn per line (1..2**OBJW).
XMIN, 24, objects with x<=XMIN are not drawn.
HOFFSET, 6, constant added to the buffer write address.

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  system clock
cen  in  1  step enable; all state advances only when cen=1
hinit  in  1  start of line; pulse of at least one clk
vrender  in  8  line being prepared
obj_addr  out  OBJW+2  object table read address {index, byte}; byte 0=y, 1=code, 2=attr, 3=x
obj_data  in  8  table data; valid on the cen step after obj_addr changes
rom_addr  out  CW+5  {code, row[3:0], half}
rom_cs  out  1  ROM request
rom_ok  in  1  rom_data valid for the current rom_addr
rom_data  in  8*BPP  8 pixels; pixel 0 in [BPP-1:0]
buf_addr  out  8  line buffer write address
buf_data  out  PALW+BPP  {palette, pixel}
buf_we  out  1  line buffer write strobe, one clk wide per cen step
busy  out  1  scan or draw in progress
ovf  out  1  MAXLINE reached on the current line; held until next hinit

Behaviour:
- Reset: obj_addr=0, rom_addr=0, rom_cs=0, buf_addr=0, buf_data=0, buf_we=0, busy=0, ovf=0, state IDLE.
- States: IDLE, RD_Y, RD_CODE, RD_ATTR, RD_X, CHECK, FETCH, WRITE, NEXT.
- IDLE: hinit moves to RD_Y with index=0, drawn count=0, ovf=0, busy=1.
- RD_*: one cen step per byte; the byte index advances each step.
- Byte decode:
  - y is stored inverted: ypos=~y.
  - Object is in zone when (vrender-ypos) mod 256 is in 0..15.
  - row=vrender-ypos, 4 bits, XORed with {4{attr[7]}} (vflip).
  - hflip=attr[6].
- CHECK: if in zone and x>XMIN, go to FETCH with half=hflip and buf_addr=x+HOFFSET+(hflip?15:0), 8-bit wrap. Otherwise go to NEXT.
- FETCH: rom_cs=1 with rom_addr={code,row,half}. Wait for rom_ok, latch rom_data, drop rom_cs, go to WRITE.
- WRITE: 8 cen steps, one per pixel.
  - Pixel order is 0..7 when hflip=0 and 7..0 when hflip=1; the step order is always 0..7 and only the pixel order reverses.
  - buf_data={attr[PALW-1:0],pix}.
  - buf_we=1 only if pix!=0 (transparent pixels are skipped, but buf_addr still advances).
  - buf_addr steps +1, or -1 when hflip.
  - After 8 steps: if the second half has not been drawn, toggle half and return to FETCH. Otherwise increment the drawn count and go to NEXT.
- NEXT:
  - If drawn count == MAXLINE: set ovf, go to IDLE.
  - Else if index == 2**OBJW-1: go to IDLE.
  - Else index+1, go to RD_Y.
- busy=0 in IDLE.
- Priority: objects are drawn in ascending index, so a higher index overwrites a lower one at the same address.
- hinit while not IDLE: abort immediately on the next cen step. rom_cs=0, buf_we=0, then restart as if from IDLE. ovf is cleared.
- rom_ok is ignored while rom_cs=0. A late rom_ok after an abort must not cause a write.
- rst mid-operation returns all outputs to reset values on the same edge.

Test Plan:
- One object: y=~8'h40, code=8'h12, attr=8'h03, x=8'h30, vrender=8'h45, then hinit. Expect rom_addr {12h,5,0}, then {12h,5,1}. Expect 16 writes at addresses 36h..45h with buf_data[7:4]=3, with pixels equal to 0 skipped.
- Same object with attr=8'hC3 (hflip+vflip): first rom_addr {12h,A,1}; addresses descend 45h..36h; pixel order reversed.
- Object with x=8'd24: expect no rom_cs and no buf_we. Object with ypos=vrender+1: expect it skipped.
- 12 in-zone objects with MAXLINE=8: exactly 8 objects fetched (16 ROM reads), ovf=1, busy falls; ovf clears on the next hinit.
- rom_ok held low for 20 clk during FETCH: rom_cs stays high and no writes occur; writes resume after rom_ok rises.
- hinit asserted during WRITE of object 3: buf_we stops, rom_cs=0, obj_addr returns to 0 and the scan restarts.
